// File: rtl/banked_gpr_file.sv
// Banked general-purpose RAM for the PIC16F core: per-bank GPR storage plus a common
// region visible from every bank, registered read with write-first bypass, and a clear sequencer.
module banked_gpr_file #(
    parameter int  NUM_BANKS    = 4,
    parameter int  GP_START     = 'h20,
    parameter int  GP_LEN       = 80,
    parameter int  SHARED_START = 'h70,
    parameter int  SHARED_LEN   = 16,
    localparam int ADDR_W       = 7 + $clog2(NUM_BANKS),
    localparam int TOTAL        = NUM_BANKS * GP_LEN + SHARED_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [7:0]        data_in,
    input  logic              clear_req,
    output logic [7:0]        data_out,
    output logic              ram_hit,
    output logic              busy,
    output logic              wr_ignored,
    output logic              dbg_state
);

    localparam int GP_SIZE = NUM_BANKS * GP_LEN;
    localparam int GP_IW   = (GP_SIZE > 1) ? $clog2(GP_SIZE) : 1;
    localparam int SH_IW   = (SHARED_LEN > 1) ? $clog2(SHARED_LEN) : 1;
    localparam int CLR_W   = $clog2(TOTAL);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [7:0] gp_mem [GP_SIZE];
    logic [7:0] sh_mem [SHARED_LEN];

    logic [0:0]       state_q, state_d;
    logic [CLR_W-1:0] clr_q, clr_d;
    logic [7:0]       dout_q, dout_d;
    logic             hit_q, hit_d;
    logic             wign_q, wign_d;

    logic [31:0]      off_w, bank_w;
    logic             gp_hit, sh_hit, any_hit;
    logic [GP_IW-1:0] gp_idx, clr_gp_idx;
    logic [SH_IW-1:0] sh_idx, clr_sh_idx;
    logic             clr_in_gp, clr_last;
    logic [7:0]       rd_byte;

    // The bank field is ignored for the common region so every bank aliases it.
    assign off_w   = 32'(addr[6:0]);
    assign bank_w  = 32'(addr[ADDR_W-1:7]);
    assign gp_hit  = (off_w >= GP_START) && (off_w < GP_START + GP_LEN);
    assign sh_hit  = (off_w >= SHARED_START) && (off_w < SHARED_START + SHARED_LEN);
    assign any_hit = gp_hit || sh_hit;
    assign gp_idx  = GP_IW'(bank_w * GP_LEN + off_w - GP_START);
    assign sh_idx  = SH_IW'(off_w - SHARED_START);

    assign clr_in_gp  = 32'(clr_q) < GP_SIZE;
    assign clr_gp_idx = GP_IW'(clr_q);
    assign clr_sh_idx = SH_IW'(32'(clr_q) - GP_SIZE);
    assign clr_last   = 32'(clr_q) == TOTAL - 1;

    assign rd_byte = gp_hit ? gp_mem[gp_idx] : (sh_hit ? sh_mem[sh_idx] : 8'h00);

    // Storage carries no reset; its contents are defined only by the clear sequence.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            if (clr_in_gp) gp_mem[clr_gp_idx] <= 8'h00;
            else           sh_mem[clr_sh_idx] <= 8'h00;
        end else if (wr_en && gp_hit) begin
            gp_mem[gp_idx] <= data_in;
        end else if (wr_en && sh_hit) begin
            sh_mem[sh_idx] <= data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        dout_d  = 8'h00;
        hit_d   = 1'b0;
        wign_d  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                wign_d = wr_en;
                clr_d  = clr_q + CLR_W'(1);
                if (clr_last) begin
                    state_d = S_IDLE;
                    clr_d   = '0;
                end
            end
            default: begin
                hit_d  = any_hit;
                wign_d = wr_en && !any_hit;
                dout_d = (wr_en && any_hit) ? data_in : rd_byte;
                // A write in the request cycle still lands; the clear then wipes it.
                if (clear_req) begin
                    state_d = S_CLEAR;
                    clr_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLEAR;
            clr_q   <= '0;
            dout_q  <= 8'h00;
            hit_q   <= 1'b0;
            wign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            dout_q  <= dout_d;
            hit_q   <= hit_d;
            wign_q  <= wign_d;
        end
    end

    assign data_out   = dout_q;
    assign ram_hit    = hit_q;
    assign wr_ignored = wign_q;
    assign busy       = (state_q == S_CLEAR);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_banked_gpr_file.sv
// Bench for banked_gpr_file: address-level reference model checked every cycle,
// plus directed accesses with hand-computed expectations.
module tb_banked_gpr_file;

    localparam int TOTAL = 336;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] addr = '0;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       clear_req = 1'b0;
    logic [7:0] data_out;
    logic       ram_hit, busy, wr_ignored, dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    banked_gpr_file dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .clear_req  (clear_req),
        .data_out   (data_out),
        .ram_hit    (ram_hit),
        .busy       (busy),
        .wr_ignored (wr_ignored),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: memory indexed by canonical address (common offsets fold to bank 0).
    logic [7:0] m_mem [512];
    int         m_busy_left = TOTAL;
    logic [7:0] exp_do  = 8'h00;
    logic       exp_hit = 1'b0;
    logic       exp_wi  = 1'b0;
    int         cur_key;

    function automatic int key_of(input logic [8:0] a);
        int off;
        off = int'(a[6:0]);
        if (off >= 'h20 && off < 'h70) return int'(a);
        if (off >= 'h70 && off < 'h80) return off;
        return -1;
    endfunction

    always_comb cur_key = key_of(addr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy_left <= TOTAL;
            exp_do      <= 8'h00;
            exp_hit     <= 1'b0;
            exp_wi      <= 1'b0;
            for (int i = 0; i < 512; i++) m_mem[i] <= 8'h00;
        end else if (m_busy_left > 0) begin
            exp_do      <= 8'h00;
            exp_hit     <= 1'b0;
            exp_wi      <= wr_en;
            m_busy_left <= m_busy_left - 1;
        end else begin
            if (cur_key >= 0) begin
                exp_hit <= 1'b1;
                exp_wi  <= 1'b0;
                if (wr_en) begin
                    m_mem[cur_key] <= data_in;
                    exp_do         <= data_in;
                end else begin
                    exp_do <= m_mem[cur_key];
                end
            end else begin
                exp_hit <= 1'b0;
                exp_do  <= 8'h00;
                exp_wi  <= wr_en;
            end
            if (clear_req) begin
                m_busy_left <= TOTAL;
                for (int i = 0; i < 512; i++) m_mem[i] <= 8'h00;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model.data_out", data_out, exp_do);
        chk("model.ram_hit", {7'b0, ram_hit}, {7'b0, exp_hit});
        chk("model.wr_ignored", {7'b0, wr_ignored}, {7'b0, exp_wi});
        chk("model.busy", {7'b0, busy}, {7'b0, m_busy_left > 0});
    end

    task automatic drive(input logic [8:0] a, input logic we, input logic [7:0] d, input logic cr);
        addr      = a;
        wr_en     = we;
        data_in   = d;
        clear_req = cr;
    endtask

    task automatic drive_idle();
        drive(9'h000, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic lit(input string name, input logic [7:0] e_do, input logic e_hit,
                       input logic e_wi, input logic e_busy);
        chk({name, ".data_out"}, data_out, e_do);
        chk({name, ".ram_hit"}, {7'b0, ram_hit}, {7'b0, e_hit});
        chk({name, ".wr_ignored"}, {7'b0, wr_ignored}, {7'b0, e_wi});
        chk({name, ".busy"}, {7'b0, busy}, {7'b0, e_busy});
    endtask

    task automatic xfer(input string name, input logic [8:0] a, input logic we, input logic [7:0] d,
                        input logic [7:0] e_do, input logic e_hit, input logic e_wi);
        @(negedge clk);
        drive(a, we, d, 1'b0);
        @(negedge clk);
        lit(name, e_do, e_hit, e_wi, 1'b0);
        drive_idle();
    endtask

    // Counts negedges with busy high starting at the current one; returns the run length.
    task automatic busy_run(output int len);
        len = 0;
        for (int k = 0; k < 2000; k++) begin
            if (busy !== 1'b1) break;
            len++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset_and_measure(input string name);
        int len;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        lit({name, ".in_reset"}, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        busy_run(len);
        chk_int({name, ".busy_len"}, len, TOTAL);
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    endtask

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    initial begin
        int len, pre;
        drive_idle();
        repeat (3) @(negedge clk);
        lit("reset", 8'h00, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        busy_run(len);
        chk_int("reset_clear.busy_len", len, TOTAL);

        // Fill some locations with garbage, then reset and prove the clear wipes them.
        xfer("pre_w020", 9'h020, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b0);
        xfer("pre_w16f", 9'h16F, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0);
        xfer("pre_w07f", 9'h07F, 1'b1, 8'hE7, 8'hE7, 1'b1, 1'b0);
        xfer("pre_r16f", 9'h16F, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0);
        pulse_reset_and_measure("rst_clear");
        xfer("clr_r020", 9'h020, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        xfer("clr_r16f", 9'h16F, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        xfer("clr_r07f", 9'h07F, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        xfer("bank_w020", 9'h020, 1'b1, 8'h11, 8'h11, 1'b1, 1'b0);
        xfer("bank_w0a0", 9'h0A0, 1'b1, 8'h22, 8'h22, 1'b1, 1'b0);
        xfer("bank_r020", 9'h020, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0);
        xfer("bank_r0a0", 9'h0A0, 1'b0, 8'h00, 8'h22, 1'b1, 1'b0);

        xfer("com_w1f0", 9'h1F0, 1'b1, 8'h5A, 8'h5A, 1'b1, 1'b0);
        xfer("com_r070", 9'h070, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0);
        xfer("com_r0f0", 9'h0F0, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0);
        xfer("com_r170", 9'h170, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0);

        xfer("byp_w030", 9'h030, 1'b1, 8'hC3, 8'hC3, 1'b1, 1'b0);
        xfer("byp_r030", 9'h030, 1'b0, 8'h00, 8'hC3, 1'b1, 1'b0);

        xfer("miss_w005", 9'h005, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1);
        xfer("miss_r005", 9'h005, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        xfer("miss_r01f", 9'h01F, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        xfer("edge_w0ef", 9'h0EF, 1'b1, 8'h81, 8'h81, 1'b1, 1'b0);
        xfer("edge_r0ef", 9'h0EF, 1'b0, 8'h00, 8'h81, 1'b1, 1'b0);
        xfer("edge_r06f", 9'h06F, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        xfer("edge_w1ff", 9'h1FF, 1'b1, 8'h42, 8'h42, 1'b1, 1'b0);
        xfer("edge_r07f", 9'h07F, 1'b0, 8'h00, 8'h42, 1'b1, 1'b0);

        // Write in the same cycle as clear_req behaves as a normal IDLE write.
        @(negedge clk);
        drive(9'h021, 1'b1, 8'h99, 1'b1);
        @(negedge clk);
        lit("wr_with_clear", 8'h99, 1'b1, 1'b0, 1'b1);
        drive_idle();
        busy_run(len);
        chk_int("wr_with_clear.busy_len", len, TOTAL);
        xfer("after_clr_r021", 9'h021, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        xfer("after_clr_r0a0", 9'h0A0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Write and second request during CLEAR are both ignored.
        @(negedge clk);
        drive(9'h000, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        pre = 1;
        drive(9'h020, 1'b1, 8'h77, 1'b0);
        @(negedge clk);
        lit("midclr_drop", 8'h00, 1'b0, 1'b1, 1'b1);
        pre++;
        drive(9'h000, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        drive_idle();
        busy_run(len);
        chk_int("midclr.busy_len", pre + len, TOTAL);
        xfer("midclr_r020", 9'h020, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Reset 100 cycles into a clear restarts it from the beginning.
        @(negedge clk);
        drive(9'h000, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        drive_idle();
        repeat (98) @(negedge clk);
        pulse_reset_and_measure("rst_midclr");

        xfer("final_w1f5", 9'h1F5, 1'b1, 8'h6D, 8'h6D, 1'b1, 1'b0);
        xfer("final_r075", 9'h075, 1'b0, 8'h00, 8'h6D, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        summary();
        $finish;
    end

endmodule
